// File: rtl/cache_dre_ctrl.sv
// cache_dre_ctrl
// Controller that owns the DRE (data-readable-enable) RAM while it clears the
// whole array, invalidates one row of one channel, or read-modify-writes the
// readable bits of one entry.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   clear_req / clear_done       sweep request / one-cycle completion pulse
//   fill_req/addr/channel/mask   OR mask into one entry / fill_ack pulse
//   inv_req/addr/channel         zero one row of one channel / inv_ack pulse
//   sel, busy                    controller owns the RAM (state != IDLE)
//   ri_read*  / ri_readData      DRE read port (data returns one cycle later)
//   ri_write*                    DRE write port
//   dbg_state                    current FSM state, for checkers
//
// Handshake: fill_req and inv_req are level requests held by the requester
// until the matching ack; an ack is a one-cycle pulse in the cycle the write
// is on the RAM port. clear_req is sampled only in IDLE; clear_done pulses in
// the cycle the last entry of the sweep is written. Only one request is
// accepted per IDLE cycle (clear > inv > fill) and every operation returns to
// IDLE for at least one cycle, so acks can never coincide.

module cache_dre_ctrl #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  clear_done,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [1:0]            fill_channel,
    input  logic [3:0]            fill_mask,
    output logic                  fill_ack,
    input  logic                  inv_req,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic [1:0]            inv_channel,
    output logic                  inv_ack,
    output logic                  sel,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ri_readAddress,
    output logic [1:0]            ri_readChannel,
    input  logic [7:0]            ri_readData,
    output logic [ADDR_WIDTH-1:0] ri_writeAddress,
    output logic [1:0]            ri_writeChannel,
    output logic                  ri_writeEnable,
    output logic [7:0]            ri_writeData,
    output logic [2:0]            dbg_state
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_INV    = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;      // {row, channel} sweep position
    logic [ADDR_WIDTH-1:0] op_addr_q;
    logic [1:0]            op_ch_q;
    logic [3:0]            op_mask_q;
    logic                  sel_q;
    logic [7:0]            fill_bits;

    // Reset lands in CLEAR with the counter at zero, so the RAM is swept
    // clean after every reset without anyone asking for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            op_addr_q <= '0;
            op_ch_q   <= '0;
            op_mask_q <= '0;
            sel_q     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        sel_q   <= 1'b1;
                    end else if (inv_req) begin
                        state_q   <= S_INV;
                        op_addr_q <= inv_addr;
                        op_ch_q   <= inv_channel;
                        sel_q     <= 1'b1;
                    end else if (fill_req) begin
                        state_q   <= S_RMW_RD;
                        op_addr_q <= fill_addr;
                        op_ch_q   <= fill_channel;
                        op_mask_q <= fill_mask;
                        sel_q     <= 1'b1;
                    end
                end
                // clear_req is not looked at here: the running sweep covers it.
                S_CLEAR: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        sel_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RMW_RD: state_q <= S_RMW_WR;
                S_INV, S_RMW_WR: begin
                    state_q <= S_IDLE;
                    sel_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    sel_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign busy      = sel_q;
    assign dbg_state = state_q;

    // Address bit 0 picks the upper (1) or lower (0) nibble of the row.
    assign fill_bits = {{4{op_addr_q[0]}}, {4{~op_addr_q[0]}}} & {2{op_mask_q}};

    // RAM port decode from the state flops only. The CLEAR write is held off
    // while rst is high so reset itself never writes; count 0 is written in
    // the first cycle after release.
    always_comb begin
        ri_readAddress  = '0;
        ri_readChannel  = '0;
        ri_writeAddress = '0;
        ri_writeChannel = '0;
        ri_writeEnable  = 1'b0;
        ri_writeData    = '0;
        clear_done      = 1'b0;
        inv_ack         = 1'b0;
        fill_ack        = 1'b0;
        case (state_q)
            S_CLEAR: begin
                ri_writeEnable  = ~rst;
                ri_writeAddress = {cnt_q[CW-1:2], 1'b0};
                ri_writeChannel = cnt_q[1:0];
                clear_done      = ~rst && (cnt_q == CNT_LAST);
            end
            S_INV: begin
                ri_writeEnable  = 1'b1;
                ri_writeAddress = {op_addr_q[ADDR_WIDTH-1:1], 1'b0};
                ri_writeChannel = op_ch_q;
                inv_ack         = 1'b1;
            end
            S_RMW_RD: begin
                ri_readAddress = op_addr_q;
                ri_readChannel = op_ch_q;
            end
            S_RMW_WR: begin
                ri_readAddress  = op_addr_q;
                ri_readChannel  = op_ch_q;
                ri_writeEnable  = 1'b1;
                ri_writeAddress = op_addr_q;
                ri_writeChannel = op_ch_q;
                ri_writeData    = ri_readData | fill_bits;
                fill_ack        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_dre_ctrl.md
CACHE_DRE_CTRL -- requirements
Module: cache_dre_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 9, DRE entry address width; bit 0 selects the 4-byte half of a RAM row, bits [ADDR_WIDTH-1:1] select the row.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 clear_req  input  1  request to zero every DRE entry in all 4 channels.
REQ-006 clear_done  output  1  one-cycle pulse when a clear sweep completes.
REQ-007 fill_req  input  1  request to OR fill_mask into the readable bits of one entry; held until fill_ack.
REQ-008 fill_addr  input  ADDR_WIDTH  entry address for fill.
REQ-009 fill_channel  input  2  way for fill.
REQ-010 fill_mask  input  4  byte-readable bits to set.
REQ-011 fill_ack  output  1  one-cycle pulse in the cycle the fill write is issued.
REQ-012 inv_req  input  1  request to zero one full row (both halves) of one channel; held until inv_ack.
REQ-013 inv_addr  input  ADDR_WIDTH  entry address for invalidate; bit 0 ignored.
REQ-014 inv_channel  input  2  way for invalidate.
REQ-015 inv_ack  output  1  one-cycle pulse in the cycle the invalidate write is issued.
REQ-016 sel  output  1  DRE port select; 1 = controller owns the RAM, 0 = read/write datapath owns it.
REQ-017 busy  output  1  high in every non-IDLE state.
REQ-018 ri_readAddress  output  ADDR_WIDTH  DRE read address.
REQ-019 ri_readChannel  output  2  DRE read channel.
REQ-020 ri_readData  input  8  full row of the selected channel, one cycle after the read address.
REQ-021 ri_writeAddress  output  ADDR_WIDTH  DRE write address.
REQ-022 ri_writeChannel  output  2  DRE write channel.
REQ-023 ri_writeEnable  output  1  DRE write strobe.
REQ-024 ri_writeData  output  8  full row data written.

Function
REQ-025 States SHALL be IDLE, CLEAR, INV, RMW_RD and RMW_WR; sel = busy = (state != IDLE), registered.
REQ-026 In IDLE, arbitration priority SHALL be clear_req > inv_req > fill_req, evaluated one request per IDLE cycle; the chosen request's operands are latched on entry.
REQ-027 IDLE->CLEAR on clear_req; CLEAR SHALL use an (ADDR_WIDTH+1)-bit counter {row, channel} starting at 0, write data 8'h00, writeAddress={row,1'b0}, writeChannel=counter[1:0], writeEnable=1 every cycle.
REQ-028 CLEAR SHALL last exactly 2**(ADDR_WIDTH+1) cycles; on the cycle writing the final count, clear_done pulses and the next state is IDLE.
REQ-029 clear_req asserted while in CLEAR SHALL be ignored (the sweep in progress satisfies it).
REQ-030 IDLE->INV on inv_req; INV SHALL issue one write of 8'h00 to the latched row/channel with inv_ack=1, then return to IDLE.
REQ-031 IDLE->RMW_RD on fill_req; RMW_RD SHALL drive ri_readAddress/ri_readChannel from latched operands with no write.
REQ-032 RMW_WR SHALL hold the read address/channel, write ri_readData | ({4{a0}},{4{!a0}} & {2{mask}}) (a0 = latched fill_addr[0]) to the same entry, pulse fill_ack, then return to IDLE.
REQ-033 Every operation SHALL return through IDLE for at least one cycle, so a following RMW never reads a row in the cycle it is written.
REQ-034 ri_writeEnable SHALL be 0 in IDLE and RMW_RD; write outputs SHALL be 0 when not writing.
REQ-035 Acks SHALL never coincide; at most one of fill_ack, inv_ack, clear_done is high per cycle.

Reset
REQ-036 While rst=1: state=CLEAR, counter=0, sel=1, busy=1, fill_ack=inv_ack=clear_done=0, ri_writeEnable=0; on release the sweep starts from count 0, so the RAM is zeroed without a clear_req.
REQ-037 rst asserted mid-operation SHALL abort it without any further write or ack.

Verification
REQ-038 Release reset (ADDR_WIDTH=9) -> 1024 consecutive writes of 8'h00 covering rows 0..255 x channels 0..3, clear_done on the 1024th, sel falls the next cycle.
REQ-039 After clear, fill addr 9'h005 ch 2 mask 4'b0011 -> read row 2 ch 2 returns 8'h00, write 8'h30 to row 2 ch 2 with fill_ack; then fill addr 9'h004 mask 4'b1000 -> read 8'h30, write 8'h38.
REQ-040 inv_req and fill_req raised in the same IDLE cycle -> INV first (inv_ack), then IDLE, then RMW sequence with fill_ack; no overlap.
REQ-041 clear_req and inv_req together -> full sweep, clear_done, then the invalidate write; clear_req pulsed during CLEAR -> no second sweep.
REQ-042 rst asserted in RMW_RD -> no write, no fill_ack, sel stays 1, full sweep restarts at count 0 after release.
